// File: rtl/modstick_master_pkg.sv
// Shared encodings and constants for the Modbus RTU bus master.
// Also holds the byte-wide CRC-16/Modbus update function.
package modstick_master_pkg;

  typedef enum logic [2:0] {
    ST_RECV,
    ST_CHECK,
    ST_BUS,
    ST_WAIT_ACK,
    ST_TX
  } state_t;

  typedef enum logic [1:0] {
    RESP_READ,
    RESP_WRITE,
    RESP_EXC
  } resp_t;

  localparam logic [7:0]  FC_READ_HOLD      = 8'h03;
  localparam logic [7:0]  FC_WRITE_SINGLE   = 8'h06;
  localparam logic [7:0]  EXC_ILLEGAL_FC    = 8'h01;
  localparam logic [7:0]  EXC_ILLEGAL_VALUE = 8'h03;
  localparam logic [7:0]  EXC_TIMEOUT       = 8'h04;
  localparam logic [15:0] CRC_INIT          = 16'hFFFF;
  localparam logic [15:0] CRC_POLY          = 16'hA001;
  localparam int          MAX_QTY           = 8;
  localparam int          FRAME_LEN         = 8;

  function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/modstick_master_crc16.sv
// Byte-wide CRC-16/Modbus accumulator with synchronous clear.
module crc16_modbus
  import modstick_master_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc <= CRC_INIT;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc16_update(crc, data);
    end
  end

endmodule

// File: rtl/modstick_master.sv
// Modbus RTU slave front end that acts as initiator on a simple register bus:
// decodes fc 03/06 requests, runs bus transactions, streams the RTU response.
module modstick_master
  import modstick_master_pkg::*;
#(
  parameter logic [7:0] SLAVE_ID    = 8'h01,
  parameter int         ACK_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_eof,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        valid,
  output logic        iswrite,
  output logic [15:0] addr,
  output logic [15:0] wdata,
  input  logic [15:0] rdata,
  input  logic        ack,
  output logic        frame_err
);

  state_t      state, state_next;
  resp_t       resp_kind;
  logic [3:0]  rx_cnt;
  logic [7:0]  req [FRAME_LEN];
  logic [15:0] rbuf [MAX_QTY];
  logic [3:0]  qty, idx;
  logic [7:0]  timer;
  logic [7:0]  exc_code, exc_next;
  logic        bcast, load_req, set_exc;
  logic [4:0]  tx_idx, pl_len, dat_off;
  logic [15:0] rx_crc, tx_crc, req_addr, req_val, word;
  logic [7:0]  tx_byte;
  logic        frame_ok, for_us, qty_ok, last_txn, timer_last, tx_fire;

  assign req_addr   = {req[2], req[3]};
  assign req_val    = {req[4], req[5]};
  assign frame_ok   = (rx_cnt == 4'd8) && (rx_crc == {req[7], req[6]});
  assign for_us     = (req[0] == SLAVE_ID) || (req[0] == 8'h00);
  assign qty_ok     = (req_val != 16'd0) && (req_val <= 16'(MAX_QTY));
  assign last_txn   = (idx + 4'd1) == qty;
  assign timer_last = timer == 8'(ACK_TIMEOUT - 1);
  assign valid      = (state == ST_BUS);
  assign tx_valid   = (state == ST_TX);
  assign tx_fire    = tx_valid && tx_ready;
  assign tx_data    = tx_valid ? tx_byte : 8'h00;

  // Only the six header bytes feed the receive CRC; the trailing two are compared against it.
  crc16_modbus u_rx_crc (
    .clk   (clk),
    .reset (reset),
    .clr   (state != ST_RECV),
    .en    ((state == ST_RECV) && rx_valid && (rx_cnt < 4'd6)),
    .data  (rx_data),
    .crc   (rx_crc)
  );

  crc16_modbus u_tx_crc (
    .clk   (clk),
    .reset (reset),
    .clr   (state != ST_TX),
    .en    (tx_fire && (tx_idx < pl_len)),
    .data  (tx_byte),
    .crc   (tx_crc)
  );

  always_comb begin
    state_next = state;
    load_req   = 1'b0;
    set_exc    = 1'b0;
    exc_next   = EXC_TIMEOUT;
    case (state)
      ST_RECV: if (rx_eof) state_next = ST_CHECK;
      ST_CHECK: begin
        state_next = ST_RECV;
        if (frame_ok && for_us) begin
          if (req[0] == 8'h00) begin
            if (req[1] == FC_WRITE_SINGLE) begin
              state_next = ST_BUS;
              load_req   = 1'b1;
            end
          end else if (req[1] == FC_READ_HOLD) begin
            if (qty_ok) begin
              state_next = ST_BUS;
              load_req   = 1'b1;
            end else begin
              state_next = ST_TX;
              set_exc    = 1'b1;
              exc_next   = EXC_ILLEGAL_VALUE;
            end
          end else if (req[1] == FC_WRITE_SINGLE) begin
            state_next = ST_BUS;
            load_req   = 1'b1;
          end else begin
            state_next = ST_TX;
            set_exc    = 1'b1;
            exc_next   = EXC_ILLEGAL_FC;
          end
        end
      end
      ST_BUS: state_next = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (ack) begin
          if (last_txn) state_next = bcast ? ST_RECV : ST_TX;
          else          state_next = ST_BUS;
        end else if (timer_last) begin
          state_next = bcast ? ST_RECV : ST_TX;
          set_exc    = 1'b1;
          exc_next   = EXC_TIMEOUT;
        end
      end
      ST_TX: if (tx_fire && (tx_idx == pl_len + 5'd1)) state_next = ST_RECV;
      default: state_next = ST_RECV;
    endcase
  end

  // Payload byte mux; the two CRC bytes follow the payload.
  always_comb begin
    case (resp_kind)
      RESP_READ:  pl_len = 5'd3 + {qty, 1'b0};
      RESP_WRITE: pl_len = 5'd6;
      default:    pl_len = 5'd3;
    endcase
    dat_off = tx_idx - 5'd3;
    word    = rbuf[dat_off[3:1]];
    tx_byte = 8'h00;
    if (tx_idx < pl_len) begin
      case (resp_kind)
        RESP_WRITE: tx_byte = req[tx_idx[2:0]];
        RESP_READ: begin
          if (tx_idx == 5'd0)      tx_byte = req[0];
          else if (tx_idx == 5'd1) tx_byte = FC_READ_HOLD;
          else if (tx_idx == 5'd2) tx_byte = {3'b000, qty, 1'b0};
          else                     tx_byte = dat_off[0] ? word[7:0] : word[15:8];
        end
        default: begin
          if (tx_idx == 5'd0)      tx_byte = req[0];
          else if (tx_idx == 5'd1) tx_byte = req[1] | 8'h80;
          else                     tx_byte = exc_code;
        end
      endcase
    end else if (tx_idx == pl_len) begin
      tx_byte = tx_crc[7:0];
    end else begin
      tx_byte = tx_crc[15:8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RECV;
      rx_cnt    <= 4'd0;
      qty       <= 4'd0;
      idx       <= 4'd0;
      timer     <= 8'd0;
      resp_kind <= RESP_EXC;
      exc_code  <= 8'h00;
      bcast     <= 1'b0;
      tx_idx    <= 5'd0;
      addr      <= 16'h0000;
      wdata     <= 16'h0000;
      iswrite   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      frame_err <= (state == ST_CHECK) && !frame_ok;
      if (state != ST_RECV)                  rx_cnt <= 4'd0;
      else if (rx_valid && rx_cnt != 4'd9)   rx_cnt <= rx_cnt + 4'd1;
      if (load_req) begin
        addr      <= req_addr;
        wdata     <= req_val;
        iswrite   <= (req[1] == FC_WRITE_SINGLE);
        qty       <= (req[1] == FC_WRITE_SINGLE) ? 4'd1 : req_val[3:0];
        idx       <= 4'd0;
        bcast     <= (req[0] == 8'h00);
        resp_kind <= (req[1] == FC_WRITE_SINGLE) ? RESP_WRITE : RESP_READ;
      end
      if (set_exc) begin
        resp_kind <= RESP_EXC;
        exc_code  <= exc_next;
      end
      if (state == ST_BUS)           timer <= 8'd0;
      else if (state == ST_WAIT_ACK) timer <= timer + 8'd1;
      if (state == ST_WAIT_ACK && ack) begin
        idx <= idx + 4'd1;
        if (!iswrite) addr <= addr + 16'd1;
      end
      if (state != ST_TX) tx_idx <= 5'd0;
      else if (tx_fire)   tx_idx <= tx_idx + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_RECV && rx_valid && rx_cnt < 4'd8) req[rx_cnt[2:0]] <= rx_data;
    if (state == ST_WAIT_ACK && ack && !iswrite)       rbuf[idx[2:0]] <= rdata;
  end

endmodule

// File: tb/tb_modstick_master.sv
// Directed, table-driven bench for modstick_master with a simple bus responder
// (rdata = addr + 0x1234) and a randomly stalling transmit sink.
module tb_modstick_master;

  logic        clk, reset, rx_valid, rx_eof, tx_valid, tx_ready;
  logic        valid, iswrite, ack, frame_err;
  logic [7:0]  rx_data, tx_data;
  logic [15:0] addr, wdata, rdata;

  modstick_master #(.SLAVE_ID(8'h01), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_eof(rx_eof),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .valid(valid), .iswrite(iswrite), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .frame_err(frame_err)
  );

  typedef struct {
    logic [47:0]  req;
    int           nbytes;
    logic         bad_crc;
    logic         stray;
    int           ack_delay;   // -1 never, 0 ack in the valid cycle, d>0 ack d cycles later
    int           exp_nvalid;
    logic         exp_wr;
    logic [15:0]  exp_addr0;
    logic [15:0]  exp_addr1;
    logic [15:0]  exp_wdata;
    int           exp_ferr;
    int           exp_plen;
    logic [159:0] exp_pl;      // right-aligned payload bytes, CRC appended by the bench
  } vec_t;

  vec_t        vecs[16];
  int          nvec = 0;
  int          tests = 0, fails = 0;
  int          cyc = 0, eof_cyc = 0, first_cyc = 0;
  int          cur_ack_delay = -1;
  int          nvalid = 0, nferr = 0;
  logic [15:0] first_addr, last_addr, first_wdata;
  logic        first_wr;
  logic [7:0]  rxq[$];
  logic [7:0]  fb[9];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int v, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL vec%0d %s: got %0h, expected %0h", v, nm, act, exp);
    end
  endtask

  // Bus responder
  initial begin
    logic [15:0] a;
    ack = 1'b0;
    rdata = 16'h0000;
    forever begin
      @(negedge clk);
      ack = 1'b0;
      if (valid && reset && cur_ack_delay >= 0) begin
        a = addr;
        repeat (cur_ack_delay) @(negedge clk);
        ack = 1'b1;
        rdata = a + 16'h1234;
      end
    end
  end

  // Bus / frame_err monitor
  initial begin
    forever begin
      @(negedge clk);
      if (valid) begin
        if (nvalid == 0) begin
          first_addr  = addr;
          first_wdata = wdata;
          first_wr    = iswrite;
          first_cyc   = cyc;
        end
        last_addr = addr;
        nvalid++;
      end
      if (frame_err) nferr++;
    end
  end

  // Transmit sink with random back-pressure
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      tx_ready = ($urandom_range(0, 3) != 0);
      if (tx_valid && tx_ready) rxq.push_back(tx_data);
    end
  end

  task automatic add(input logic [47:0] r, input int nb, input logic bc, input logic st,
                     input int ad, input int nvl, input logic wr, input logic [15:0] a0,
                     input logic [15:0] a1, input logic [15:0] wd, input int fe,
                     input int pl_len, input logic [159:0] pl);
    vecs[nvec].req = r;        vecs[nvec].nbytes = nb;    vecs[nvec].bad_crc = bc;
    vecs[nvec].stray = st;     vecs[nvec].ack_delay = ad; vecs[nvec].exp_nvalid = nvl;
    vecs[nvec].exp_wr = wr;    vecs[nvec].exp_addr0 = a0; vecs[nvec].exp_addr1 = a1;
    vecs[nvec].exp_wdata = wd; vecs[nvec].exp_ferr = fe;  vecs[nvec].exp_plen = pl_len;
    vecs[nvec].exp_pl = pl;
    nvec++;
  endtask

  task automatic build_frame(input int i);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < 6; k++) begin
      fb[k] = vecs[i].req[8*(5-k) +: 8];
      c = crc_byte(c, fb[k]);
    end
    fb[6] = c[7:0];
    fb[7] = c[15:8] ^ (vecs[i].bad_crc ? 8'hFF : 8'h00);
    fb[8] = 8'h00;
  endtask

  task automatic send_frame(input int n, input bit mark);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); rx_data = fb[k]; rx_valid = 1'b1;
      @(negedge clk); rx_valid = 1'b0;
    end
    @(negedge clk); rx_eof = 1'b1;
    if (mark) eof_cyc = cyc;
    @(negedge clk); rx_eof = 1'b0;
  endtask

  task automatic run_vec(input int i);
    logic [15:0] c;
    logic [7:0]  expb[24];
    int          elen, pl;
    nvalid = 0; nferr = 0; rxq.delete();
    cur_ack_delay = vecs[i].ack_delay;
    build_frame(i);
    send_frame(vecs[i].nbytes, 1'b1);
    if (vecs[i].stray) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge clk); rx_data = 8'hA5; rx_valid = 1'b1;
      end
      @(negedge clk); rx_valid = 1'b0; rx_eof = 1'b1;
      @(negedge clk); rx_eof = 1'b0;
    end
    pl = vecs[i].exp_plen;
    elen = 0;
    if (pl > 0) begin
      c = 16'hFFFF;
      for (int k = 0; k < pl; k++) begin
        expb[k] = vecs[i].exp_pl[8*(pl-1-k) +: 8];
        c = crc_byte(c, expb[k]);
      end
      expb[pl] = c[7:0];
      expb[pl+1] = c[15:8];
      elen = pl + 2;
    end
    for (int k = 0; k < 400 && rxq.size() < elen; k++) @(negedge clk);
    repeat (60) @(negedge clk);
    chk("resp_len", i, rxq.size(), elen);
    for (int k = 0; k < elen && k < rxq.size(); k++) chk("resp_byte", i, rxq[k], expb[k]);
    chk("valid_cycles", i, nvalid, vecs[i].exp_nvalid);
    chk("frame_err_pulses", i, nferr, vecs[i].exp_ferr);
    if (vecs[i].exp_nvalid > 0 && nvalid > 0) begin
      chk("first_addr", i, first_addr, vecs[i].exp_addr0);
      chk("last_addr", i, last_addr, vecs[i].exp_addr1);
      chk("iswrite", i, first_wr, vecs[i].exp_wr);
      chk("eof_to_valid_le3", i, ((first_cyc - eof_cyc) <= 3) ? 1 : 0, 1);
      if (vecs[i].exp_wr) chk("wdata", i, first_wdata, vecs[i].exp_wdata);
    end
    $display("[TB] vec %0d: req %012h len %0d -> %0d resp bytes, %0d bus cycles, %0d frame errors",
             i, vecs[i].req, vecs[i].nbytes, rxq.size(), nvalid, nferr);
  endtask

  initial begin
    //   req                      nb bad st  ack nv wr a0        a1        wdata     fe pl payload
    add(48'h01_03_0000_0001,      8, 0, 0,  1,  1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 5, 160'h01_03_02_12_34);
    add(48'h01_06_0003_BEEF,      8, 0, 0,  2,  1, 1, 16'h0003, 16'h0003, 16'hBEEF, 0, 6, 160'h01_06_00_03_BE_EF);
    add(48'h01_03_0000_0001,      8, 1, 0,  1,  0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 160'h0);
    add(48'h01_03_0000_0009,      8, 0, 0,  1,  0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 3, 160'h01_83_03);
    add(48'h01_10_0000_0001,      8, 0, 0,  1,  0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 3, 160'h01_90_01);
    add(48'h01_03_0000_0002,      8, 0, 1, -1,  1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 3, 160'h01_83_04);
    add(48'h00_06_0010_5555,      8, 0, 0,  1,  1, 1, 16'h0010, 16'h0010, 16'h5555, 0, 0, 160'h0);
    add(48'h01_03_FFFF_0003,      8, 0, 0,  8,  3, 0, 16'hFFFF, 16'h0001, 16'h0000, 0, 9,
        160'h01_03_06_12_33_12_34_12_35);
    add(48'h05_03_0000_0001,      8, 0, 0,  1,  0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 160'h0);
    add(48'h01_03_0000_0001,      9, 0, 0,  1,  0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 160'h0);
    add(48'h01_03_0000_0000,      8, 0, 0,  1,  0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 3, 160'h01_83_03);
    add(48'h00_03_0000_0001,      8, 0, 0,  1,  0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 160'h0);
    add(48'h01_06_0020_1234,      8, 0, 0,  9,  1, 1, 16'h0020, 16'h0020, 16'h1234, 0, 3, 160'h01_86_04);
    add(48'h01_03_0004_0001,      8, 0, 0,  0,  1, 0, 16'h0004, 16'h0004, 16'h0000, 0, 3, 160'h01_83_04);
    add(48'h01_06_0001_0001,      7, 0, 0,  1,  0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 160'h0);
    add(48'h01_03_0100_0008,      8, 0, 0,  1,  8, 0, 16'h0100, 16'h0107, 16'h0000, 0, 19,
        160'h01_03_10_13_34_13_35_13_36_13_37_13_38_13_39_13_3A_13_3B);

    reset = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_eof = 1'b0;
    repeat (2) @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h55;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("reset_tx_valid", -1, tx_valid, 0);
    chk("reset_tx_data", -1, tx_data, 0);
    chk("reset_valid", -1, valid, 0);
    chk("reset_iswrite", -1, iswrite, 0);
    chk("reset_addr", -1, addr, 0);
    chk("reset_wdata", -1, wdata, 0);
    chk("reset_frame_err", -1, frame_err, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < nvec; i++) run_vec(i);

    // Reset while a response is streaming: output drops at once and nothing resumes.
    nvalid = 0; rxq.delete(); cur_ack_delay = 1;
    build_frame(0);
    send_frame(8, 1'b1);
    for (int k = 0; k < 200 && rxq.size() < 2; k++) @(negedge clk);
    chk("tx_started", 99, (rxq.size() >= 2) ? 1 : 0, 1);
    #1 reset = 1'b0;
    #1;
    chk("mid_tx_reset_tx_valid", 99, tx_valid, 0);
    chk("mid_tx_reset_tx_data", 99, tx_data, 0);
    chk("mid_tx_reset_valid", 99, valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rxq.delete();
    repeat (40) @(negedge clk);
    chk("no_resume_after_reset", 99, rxq.size(), 0);
    $display("[TB] reset during tx: %0d bytes after release", rxq.size());
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/modstick_master.md
MODSTICK_MASTER -- requirements
Module: modstick_master

Interface
REQ-001 SLAVE_ID, 8'h01, station address this block answers; address 0 is broadcast.
REQ-002 ACK_TIMEOUT, 8, bus cycles to wait for ack before reporting exception 04.
REQ-003 clk  in  1  reference clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 rx_data  in  8  received byte.
REQ-006 rx_valid  in  1  one-cycle strobe per received byte.
REQ-007 rx_eof  in  1  one-cycle end-of-frame pulse (inter-frame gap); never coincident with rx_valid.
REQ-008 tx_data  out  8  response byte.
REQ-009 tx_valid  out  1  tx_data valid; held with tx_data stable until tx_ready.
REQ-010 tx_ready  in  1  byte accepted when tx_valid & tx_ready.
REQ-011 valid  out  1  one-cycle bus request pulse.
REQ-012 iswrite  out  1  1=write, 0=read; stable with addr/wdata until ack or timeout.
REQ-013 addr  out  16  register address.
REQ-014 wdata  out  16  write data.
REQ-015 rdata  in  16  read data, sampled in the ack cycle.
REQ-016 ack  in  1  responder completion strobe.
REQ-017 frame_err  out  1  one-cycle pulse on a malformed or CRC-failed frame.

Function
REQ-018 Block SHALL be the bus initiator: decode Modbus RTU requests, issue bus transactions, emit RTU responses.
REQ-019 Every request SHALL be exactly 8 bytes: id, fc, addrH, addrL, qty/valH, qty/valL, crcL, crcH; CRC-16/Modbus (poly 0xA001 reflected, init 0xFFFF) over first 6 bytes.
REQ-020 States SHALL be RECV, CHECK, BUS, WAIT_ACK, TX; RECV collects bytes, rx_eof moves to CHECK.
REQ-021 In CHECK: byte count != 8 or CRC mismatch SHALL pulse frame_err and return to RECV with no response; bytes beyond 8 are counted but not stored (count saturates at 9).
REQ-022 id not SLAVE_ID and not 0 SHALL return silently to RECV without frame_err.
REQ-023 fc 0x03 (read holding, qty 1..8) SHALL issue qty reads at addr, addr+1, ... (16-bit wrap), buffering rdata in an 8x16 buffer.
REQ-024 fc 0x06 (write single) SHALL issue one write of val to addr.
REQ-025 Each transaction: valid high exactly one cycle (BUS), then WAIT_ACK counts up to ACK_TIMEOUT cycles; ack in any of those cycles completes it; ack in the valid cycle itself is ignored.
REQ-026 Timeout SHALL abort remaining transactions and respond with exception 04.
REQ-027 Normal 0x03 response: id, 0x03, 2*qty, dataH/dataL per register, crcL, crcH; 0x06 response: echo of the 6 request bytes plus fresh CRC.
REQ-028 Exceptions: unsupported fc -> 01; qty 0 or >8 -> 03; timeout -> 04; format id, fc|0x80, code, crcL, crcH; no bus transaction for 01/03.
REQ-029 Broadcast (id 0): 0x06 write executed, no response; all other fc ignored, no response.
REQ-030 TX SHALL compute CRC on the fly over transmitted bytes and return to RECV after crcH accepted.
REQ-031 rx_valid/rx_eof outside RECV SHALL be dropped; the next frame starts fresh after return to RECV.
REQ-032 First valid pulse SHALL follow rx_eof by at most 3 cycles for a good frame.

Reset
REQ-033 Reset SHALL force RECV, byte count 0, CRC 0xFFFF, and all outputs (tx_valid, valid, iswrite, addr, wdata, tx_data, frame_err) to 0, asynchronously.
REQ-034 Reset mid-transaction or mid-TX SHALL abandon it; no partial response resumes after release.

Structure
REQ-035 Shared package SHALL hold state encoding, function codes 0x03/0x06, exception codes 01/03/04, CRC init/poly constants, max qty 8.
REQ-036 One sub-module crc16_modbus (byte-wide update, clear, enable) SHALL be instantiated twice: RX check and TX generation.

Verification
REQ-037 Read id 01 fc 03 addr 0000 qty 0001, responder returns 0x1234 -> tx 01 03 02 12 34 + correct CRC.
REQ-038 Write id 01 fc 06 addr 0003 val BEEF -> one write pulse addr 3 wdata BEEF, echoed 8-byte response.
REQ-039 Valid frame with last CRC byte flipped -> frame_err pulse, no bus activity, no tx.
REQ-040 fc 03 qty 9 -> tx 01 83 03 + CRC; fc 10 -> 01 90 01 + CRC; no valid pulses.
REQ-041 Read qty 2, responder never acks -> after ACK_TIMEOUT cycles tx 01 83 04 + CRC, one valid pulse only.
REQ-042 Broadcast id 00 fc 06 -> write pulse, tx_valid stays 0; reset asserted during TX -> tx_valid 0 immediately, next frame answered normally.
